// File: rtl/im_pkg.sv
// Shared types and geometry for the instruction-memory access controller.
// Included by the arbiter and the top level.
package im_pkg;

  localparam int IM_ADDR_W = 11;
  localparam int IM_DATA_W = 16;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    FLUSH
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DBG,
    GNT_LOAD
  } grant_e;

endpackage

// File: rtl/im_rr_starve.sv
// Fetch/debug arbiter: fetch wins contention until debug has been refused
// MAX_WAIT consecutive cycles, then debug takes one cycle.
module im_rr_starve #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic fetch_req,
  input  logic dbg_req,
  output logic gnt_fetch,
  output logic gnt_dbg
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // NOTE: every combinational output is assigned a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_fetch = 1'b0;
    gnt_dbg   = 1'b0;
    if (en) begin
      if (dbg_req && (!fetch_req || wait_cnt == WAIT_LIMIT)) begin
        gnt_dbg = 1'b1;
      end else if (fetch_req) begin
        gnt_fetch = 1'b1;
      end
    end
  end

  // Outside RUN the count is frozen so a pending debug keeps its place.
  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (en) begin
      if (!dbg_req || gnt_dbg) begin
        wait_cnt <= '0;
      end else if (fetch_req && wait_cnt != WAIT_LIMIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/im_access_ctrl.sv
// Single-port instruction memory owner: arbitrates CPU fetch and debug reads,
// and sequences boot-loader downloads that stall the CPU.
module im_access_ctrl
  import im_pkg::*;
#(
  parameter int ADDR_W   = IM_ADDR_W,
  parameter int DATA_W   = IM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_stall,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(1 << ADDR_W);

  state_e          state, state_nxt;
  grant_e          gnt;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] wr_cnt;
  logic [ADDR_W:0] len_clamped;
  logic            arb_fetch, arb_dbg;
  logic            wr_last;

  im_rr_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == RUN),
    .fetch_req (fetch_req),
    .dbg_req   (dbg_req),
    .gnt_fetch (arb_fetch),
    .gnt_dbg   (arb_dbg)
  );

  assign len_clamped = (ld_len > MAX_LEN) ? MAX_LEN : ld_len;

  // The memory port has exactly one owner per cycle. Reset forces it idle
  // immediately, because the memory samples these controls on the next negedge.
  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (arb_dbg) begin
            gnt = GNT_DBG;
          end else if (arb_fetch) begin
            gnt = GNT_FETCH;
          end
        end
        LOAD:    if (ld_valid) gnt = GNT_LOAD;
        default: gnt = GNT_NONE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    unique case (gnt)
      GNT_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = fetch_addr;
      end
      GNT_DBG: begin
        mem_rd_en = 1'b1;
        mem_addr  = dbg_addr;
      end
      GNT_LOAD: begin
        mem_wr_en = 1'b1;
        mem_addr  = wr_cnt[ADDR_W-1:0];
        mem_wdata = ld_data;
      end
      default: mem_rd_en = 1'b0;
    endcase
  end

  assign wr_last = (gnt == GNT_LOAD) && ((wr_cnt + 1'b1) == len_q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (ld_start) state_nxt = (len_clamped == '0) ? FLUSH : LOAD;
      LOAD:    if (wr_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      len_q     <= '0;
      wr_cnt    <= '0;
      dbg_valid <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && ld_start) begin
        len_q  <= len_clamped;
        wr_cnt <= '0;
      end else if (gnt == GNT_LOAD) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      // mem_rdata at this edge holds the word read on the grant cycle's negedge.
      dbg_valid <= (gnt == GNT_DBG);
      if (gnt == GNT_DBG) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  assign dbg_gnt     = (gnt == GNT_DBG);
  assign fetch_stall = rst_n && ((state != RUN) || (fetch_req && gnt != GNT_FETCH));
  assign ld_busy     = (state != RUN);
  assign ld_ready    = (state == LOAD);
  assign ld_done     = (state == FLUSH);
  assign fetch_instr = rst_n ? mem_rdata : '0;

endmodule

// File: tb/tb_im_access_ctrl.sv
// Bench for im_access_ctrl: negedge-sampling memory model, scoreboard queues
// for memory writes and debug read-back, one task per scenario.
module tb_im_access_ctrl;
  import im_pkg::*;

  localparam int AW       = 11;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] fetch_instr;
  logic          fetch_stall;
  logic          ld_start = 1'b0;
  logic [AW:0]   ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, ld_busy, ld_done;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_gnt, dbg_valid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  im_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .fetch_stall(fetch_stall),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] mem     [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  wr_t           wr_q[$];
  logic [DW-1:0] dbg_q[$];
  int            tests = 0;
  int            fails = 0;
  int            done_cnt = 0;

  // Instruction memory: samples controls on negedge, data visible by next posedge.
  always @(negedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard monitors for writes and debug returns.
  always @(negedge clk) begin
    wr_t           e;
    logic [DW-1:0] d;
    if (mem_wr_en) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = wr_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (dbg_valid) begin
      tests++;
      if (dbg_q.size() == 0) begin
        fails++;
        $display("FAIL dbg_unexpected: got dbg_valid with rdata=%h, expected none", dbg_rdata);
      end else begin
        d = dbg_q.pop_front();
        if (dbg_rdata !== d) begin
          fails++;
          $display("FAIL dbg_rdata: got %h, expected %h", dbg_rdata, d);
        end
      end
    end
    if (ld_done) done_cnt++;
  end

  function automatic logic [66:0] all_outs();
    return {fetch_instr, fetch_stall, ld_ready, ld_busy, ld_done, dbg_gnt, dbg_valid,
            dbg_rdata, mem_addr, mem_rd_en, mem_wr_en, mem_wdata};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = 11'h010; dbg_req = 1'b1;
    ld_valid = 1'b1; ld_data = 16'hFFFF;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL reset_outs: got %h, expected 0", all_outs());
    end
    cyc();
    rst_n = 1'b1; fetch_req = 1'b0; dbg_req = 1'b0; ld_valid = 1'b0;
    #2;
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL reset_idle: got %h, expected 0", all_outs());
    end
  endtask

  task automatic test_fetch();
    logic [AW-1:0] addrs [4];
    addrs = '{11'h010, 11'h000, 11'h7FF, 11'h123};
    foreach (addrs[i]) begin
      cyc();
      fetch_req = 1'b1; fetch_addr = addrs[i];
      #2;
      tests++;
      if ({mem_rd_en, mem_addr, fetch_stall, dbg_gnt} !== {1'b1, addrs[i], 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL fetch_ctrl[%0d]: got rd=%b addr=%h stall=%b gnt=%b, expected rd=1 addr=%h stall=0 gnt=0",
                 i, mem_rd_en, mem_addr, fetch_stall, dbg_gnt, addrs[i]);
      end
      @(negedge clk);
      #1;
      tests++;
      if (fetch_instr !== ref_mem[addrs[i]]) begin
        fails++;
        $display("FAIL fetch_instr[%0d]: got %h, expected %h", i, fetch_instr, ref_mem[addrs[i]]);
      end
    end
    cyc();
    fetch_req = 1'b0;
    #2;
    tests++;
    if ({mem_rd_en, fetch_stall} !== 2'b00) begin
      fails++;
      $display("FAIL fetch_idle: got rd=%b stall=%b, expected 0 0", mem_rd_en, fetch_stall);
    end
  endtask

  task automatic test_load();
    logic [DW-1:0] words [3];
    logic          vpat  [4];
    int            k = 0;
    int            done0;
    words = '{16'h1111, 16'h2222, 16'h3333};
    vpat  = '{1'b1, 1'b0, 1'b1, 1'b1};
    cyc();
    ld_start = 1'b1; ld_len = 12'd3; fetch_req = 1'b1; fetch_addr = 11'h005;
    #2;
    tests++;
    if ({mem_rd_en, fetch_stall, ld_busy} !== 3'b100) begin
      fails++;
      $display("FAIL load_start_cycle: got rd=%b stall=%b busy=%b, expected 1 0 0",
               mem_rd_en, fetch_stall, ld_busy);
    end
    done0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      cyc();
      ld_start = 1'b0; ld_valid = vpat[i];
      ld_data  = vpat[i] ? words[k] : 16'hDEAD;
      if (vpat[i]) begin
        push_wr(AW'(k), words[k]);
        k++;
      end
      #2;
      tests++;
      if ({ld_busy, ld_ready, fetch_stall, mem_rd_en, dbg_gnt, mem_wr_en} !==
          {5'b11100, vpat[i]}) begin
        fails++;
        $display("FAIL load_word[%0d]: got busy/ready/stall/rd/gnt/wr=%b%b%b%b%b%b, expected 11100%b",
                 i, ld_busy, ld_ready, fetch_stall, mem_rd_en, dbg_gnt, mem_wr_en, vpat[i]);
      end
    end
    cyc();
    ld_valid = 1'b1; ld_data = 16'hBAD0;
    #2;
    tests++;
    if ({ld_done, ld_busy, ld_ready, fetch_stall, mem_wr_en} !== 5'b11010) begin
      fails++;
      $display("FAIL load_flush: got done/busy/ready/stall/wr=%b%b%b%b%b, expected 11010",
               ld_done, ld_busy, ld_ready, fetch_stall, mem_wr_en);
    end
    cyc();
    ld_valid = 1'b0; fetch_addr = 11'h001;
    #2;
    tests++;
    if ({ld_done, ld_busy, fetch_stall, mem_rd_en} !== 4'b0001 || done_cnt != done0 + 1) begin
      fails++;
      $display("FAIL load_release: got done/busy/stall/rd=%b%b%b%b pulses=%0d, expected 0001 pulses=1",
               ld_done, ld_busy, fetch_stall, mem_rd_en, done_cnt - done0);
    end
    @(negedge clk);
    #1;
    tests++;
    if (fetch_instr !== 16'h2222) begin
      fails++;
      $display("FAIL load_readback: got %h, expected 2222", fetch_instr);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_load_zero();
    cyc();
    ld_start = 1'b1; ld_len = '0;
    cyc();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'hBAD1;
    #2;
    tests++;
    if ({ld_done, ld_busy, ld_ready, mem_wr_en, fetch_stall} !== 5'b11001) begin
      fails++;
      $display("FAIL zero_flush: got done/busy/ready/wr/stall=%b%b%b%b%b, expected 11001",
               ld_done, ld_busy, ld_ready, mem_wr_en, fetch_stall);
    end
    cyc();
    ld_valid = 1'b0;
    #2;
    tests++;
    if ({ld_done, ld_busy} !== 2'b00) begin
      fails++;
      $display("FAIL zero_release: got done=%b busy=%b, expected 0 0", ld_done, ld_busy);
    end
  endtask

  task automatic test_load_clamp();
    logic [DW-1:0] d;
    cyc();
    ld_start = 1'b1; ld_len = 12'hFFF;
    for (int i = 0; i < 2048; i++) begin
      cyc();
      ld_start = 1'b0; ld_valid = 1'b1;
      d = DW'(i) ^ 16'hC3C3;
      ld_data = d;
      push_wr(AW'(i), d);
      if (i == 2047) begin
        #2;
        tests++;
        if ({ld_ready, ld_done, mem_wr_en} !== 3'b101) begin
          fails++;
          $display("FAIL clamp_last_word: got ready/done/wr=%b%b%b, expected 101",
                   ld_ready, ld_done, mem_wr_en);
        end
      end
    end
    cyc();
    ld_data = 16'hBAD2;
    #2;
    tests++;
    if ({ld_done, ld_ready, mem_wr_en} !== 3'b100) begin
      fails++;
      $display("FAIL clamp_flush: got done/ready/wr=%b%b%b, expected 100", ld_done, ld_ready, mem_wr_en);
    end
    cyc();
    ld_valid = 1'b0;
    #2;
    tests++;
    if (ld_busy !== 1'b0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL clamp_end: got busy=%b pending_writes=%0d, expected 0 0", ld_busy, wr_q.size());
    end
  endtask

  task automatic test_starve();
    logic [17:0]   dreq;
    logic [AW-1:0] exp_addr;
    logic          exp_dbg;
    int            wm = 0;
    dreq = 18'b11111_0_11_11111_11111;
    fetch_addr = 11'h040;
    for (int i = 0; i < 18; i++) begin
      cyc();
      fetch_req = 1'b1;
      dbg_req   = dreq[i];
      dbg_addr  = (i < 5) ? 11'h010 : (i < 10) ? 11'h7FF : 11'h003;
      exp_dbg   = dreq[i] && (wm == MAX_WAIT);
      if (exp_dbg) dbg_q.push_back(ref_mem[dbg_addr]);
      if (!dreq[i] || exp_dbg) wm = 0;
      else wm++;
      exp_addr = exp_dbg ? dbg_addr : fetch_addr;
      #2;
      tests++;
      if ({dbg_gnt, fetch_stall, mem_rd_en, mem_addr} !== {exp_dbg, exp_dbg, 1'b1, exp_addr}) begin
        fails++;
        $display("FAIL starve[%0d]: got gnt=%b stall=%b rd=%b addr=%h, expected gnt=%b stall=%b rd=1 addr=%h",
                 i, dbg_gnt, fetch_stall, mem_rd_en, mem_addr, exp_dbg, exp_dbg, exp_addr);
      end
    end
    cyc();
    fetch_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (dbg_q.size() != 0) begin
      fails++;
      $display("FAIL starve_returns: got %0d outstanding, expected 0", dbg_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int done0;
    cyc();
    ld_start = 1'b1; ld_len = 12'd5; fetch_req = 1'b1; fetch_addr = 11'h001;
    done0 = done_cnt;
    cyc();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'hBEE0;
    push_wr(11'h000, 16'hBEE0);
    cyc();
    ld_data = 16'hBEE1;
    push_wr(11'h001, 16'hBEE1);
    cyc();
    ld_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL midload_reset: got %h, expected 0", all_outs());
    end
    cyc();
    rst_n = 1'b1;
    #2;
    tests++;
    if ({fetch_stall, mem_rd_en, mem_addr, ld_busy, ld_done} !== {1'b0, 1'b1, 11'h001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midload_resume: got stall=%b rd=%b addr=%h busy=%b done=%b, expected 0 1 001 0 0",
               fetch_stall, mem_rd_en, mem_addr, ld_busy, ld_done);
    end
    @(negedge clk);
    #1;
    tests++;
    if (fetch_instr !== 16'hBEE1 || done_cnt != done0) begin
      fails++;
      $display("FAIL midload_after: got instr=%h pulses=%0d, expected BEE1 pulses=0",
               fetch_instr, done_cnt - done0);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_load_dbg();
    logic [DW-1:0] words [2];
    words = '{16'h7001, 16'h7002};
    cyc();
    ld_start = 1'b1; ld_len = 12'd2; fetch_req = 1'b1; fetch_addr = 11'h003;
    #2;
    tests++;
    if ({mem_rd_en, mem_addr, fetch_stall} !== {1'b1, 11'h003, 1'b0}) begin
      fails++;
      $display("FAIL ldbg_start: got rd=%b addr=%h stall=%b, expected 1 003 0",
               mem_rd_en, mem_addr, fetch_stall);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      ld_len = 12'd7; fetch_req = 1'b0; dbg_req = 1'b1; dbg_addr = 11'h001;
      ld_valid = 1'b1; ld_data = words[i];
      push_wr(AW'(i), words[i]);
      #2;
      tests++;
      if ({dbg_gnt, fetch_stall, mem_rd_en, mem_wr_en, ld_busy} !== 5'b01011) begin
        fails++;
        $display("FAIL ldbg_load[%0d]: got gnt/stall/rd/wr/busy=%b%b%b%b%b, expected 01011",
                 i, dbg_gnt, fetch_stall, mem_rd_en, mem_wr_en, ld_busy);
      end
    end
    cyc();
    ld_valid = 1'b0;
    #2;
    tests++;
    if ({ld_done, dbg_gnt, fetch_stall, mem_rd_en} !== 4'b1010) begin
      fails++;
      $display("FAIL ldbg_flush: got done/gnt/stall/rd=%b%b%b%b, expected 1010",
               ld_done, dbg_gnt, fetch_stall, mem_rd_en);
    end
    cyc();
    ld_start = 1'b0;
    dbg_q.push_back(ref_mem[11'h001]);
    #2;
    tests++;
    if ({dbg_gnt, ld_busy, mem_addr, mem_rd_en, fetch_stall} !== {1'b1, 1'b0, 11'h001, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL ldbg_grant: got gnt=%b busy=%b addr=%h rd=%b stall=%b, expected 1 0 001 1 0",
               dbg_gnt, ld_busy, mem_addr, mem_rd_en, fetch_stall);
    end
    cyc();
    dbg_req = 1'b0;
    #2;
    tests++;
    if ({ld_busy, dbg_gnt} !== 2'b00) begin
      fails++;
      $display("FAIL ldbg_idle: got busy=%b gnt=%b, expected 0 0", ld_busy, dbg_gnt);
    end
    @(negedge clk);
    #1;
    tests++;
    if (dbg_q.size() != 0) begin
      fails++;
      $display("FAIL ldbg_return: got %0d outstanding, expected 0", dbg_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = DW'(i * 7) ^ 16'h5A00;
      ref_mem[i] = DW'(i * 7) ^ 16'h5A00;
    end
    mem[11'h010]     = 16'hA5A5;
    ref_mem[11'h010] = 16'hA5A5;

    test_reset();
    test_fetch();
    test_load();
    test_load_zero();
    test_load_clamp();
    test_starve();
    test_reset_mid_load();
    test_load_dbg();

    repeat (2) cyc();
    tests++;
    if (wr_q.size() != 0 || dbg_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d writes %0d reads pending, expected 0 0",
               wr_q.size(), dbg_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/im_access_ctrl.md
Name: im_access_ctrl

Overview:
- Owns the single port of the 2048x16 instruction memory and shares it between three requesters: CPU fetch, boot loader (UART-fed word writes) and debug read-back.
- Sequences program download: stalls the CPU, streams words into the memory from address 0, then releases the CPU.
- Sits between the CPU fetch stage, the loader front-end and the instruction memory. The memory exposes a write port driven only by this block.

Parameters:
- ADDR_W, 11, instruction memory address width (2048 words)
- DATA_W, 16, instruction word width
- MAX_WAIT, 4, consecutive denied debug cycles before debug preempts fetch (1..15)

Ports:
- clk  in  1  system clock; memory samples on negedge, this block on posedge
- rst_n  in  1  reset, asynchronous, active-low
- fetch_req  in  1  CPU requests instruction at fetch_addr
- fetch_addr  in  ADDR_W  fetch address
- fetch_instr  out  DATA_W  mem_rdata passthrough, valid at end of a granted cycle
- fetch_stall  out  1  fetch not served this cycle
- ld_start  in  1  pulse: begin download
- ld_len  in  ADDR_W+1  word count, sampled with ld_start
- ld_valid  in  1  ld_data valid
- ld_data  in  DATA_W  word to write
- ld_ready  out  1  loader word accepted when ld_valid & ld_ready
- ld_busy  out  1  high in LOAD and FLUSH
- ld_done  out  1  one-cycle pulse at download completion
- dbg_req  in  1  debug read request, held until dbg_gnt
- dbg_addr  in  ADDR_W  debug read address
- dbg_gnt  out  1  debug granted this cycle
- dbg_valid  out  1  dbg_rdata valid, one cycle after dbg_gnt
- dbg_rdata  out  DATA_W  registered read data
- mem_addr  out  ADDR_W  memory address
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data

Behaviour:
- Reset values: all outputs 0. FSM = RUN, counters = 0.
- Memory controls are combinational from the registered state and the current requests, so the memory captures them at the negedge of the same cycle. mem_rdata is valid at the next posedge. Read latency is 0 cycles to fetch_instr and 1 cycle to dbg_rdata.
- FSM states:
  - RUN: normal operation.
  - LOAD: download in progress.
  - FLUSH: exactly one cycle; ld_done=1, then return to RUN.
- RUN arbitration:
  - fetch only: fetch granted. mem_rd_en=1, mem_addr=fetch_addr, fetch_stall=0.
  - dbg only: debug granted. dbg_gnt=1, mem_addr=dbg_addr.
  - both, wait_cnt<MAX_WAIT: fetch granted and wait_cnt++.
  - both, wait_cnt==MAX_WAIT: debug granted, fetch_stall=1.
  - wait_cnt clears on any debug grant, or whenever dbg_req=0.
  - neither: mem_rd_en=0, fetch_stall=0.
- Debug return: dbg_rdata is captured from mem_rdata at the posedge ending the grant cycle; dbg_valid=1 for the following cycle.
- RUN→LOAD on ld_start:
  - Latch len = min(ld_len, 2048); wr_addr=0.
  - If len==0, go RUN→FLUSH instead of LOAD.
  - ld_start is ignored outside RUN.
- LOAD:
  - Outputs: ld_ready=1, fetch_stall=1, dbg_gnt=0, mem_rd_en=0.
  - On ld_valid: mem_wr_en=1, mem_addr=wr_addr, mem_wdata=ld_data, wr_addr++.
  - When the accepted-word count reaches len, go to FLUSH the next cycle. ld_ready=0 from then on.
- FLUSH: fetch_stall=1, ld_ready=0, no memory access, ld_done pulse.
- Stall scope: fetch_stall=1 in LOAD and FLUSH regardless of fetch_req. Pending dbg_req waits; wait_cnt is held.
- Simultaneous ld_start and requests in RUN: the current cycle's arbitration completes normally; LOAD starts next cycle.
- Reset mid-LOAD: immediate return to RUN, no ld_done. Memory content is partially written and not restored.
- Write/read collision is impossible: a single owner per cycle is guaranteed by the FSM.

Decomposition:
- Shared package im_pkg:
  - ADDR_W/DATA_W constants
  - state enum {RUN, LOAD, FLUSH}
  - grant enum {GNT_NONE, GNT_FETCH, GNT_DBG, GNT_LOAD}
- One natural sub-module: im_rr_starve, the fetch/debug priority arbiter with the saturating wait_cnt. The top level holds the FSM, the load counter and the memory mux.

Test Plan:
- Reset then fetch_req=1, fetch_addr=0x010, memory[0x010]=0xA5A5 -> fetch_instr=0xA5A5 at end of same cycle, fetch_stall=0, mem_wr_en never 1.
- ld_start with ld_len=3, words 0x1111/0x2222/0x3333 with one ld_valid gap -> writes at addr 0,1,2; ld_busy high throughout; ld_done single pulse one cycle after third write; fetch_stall=1 in LOAD and FLUSH, 0 afterwards.
- ld_len=0 -> FLUSH immediately, ld_done pulse next cycle, no mem_wr_en. ld_len=4095 -> clamps to 2048, wr_addr wraps never.
- fetch_req and dbg_req held high, MAX_WAIT=4 -> fetch granted 4 cycles, dbg_gnt on 5th cycle with fetch_stall=1, dbg_valid next cycle with memory[dbg_addr], then pattern repeats.
- Assert rst_n low after 2 of 5 load words -> all outputs 0 asynchronously; after release FSM=RUN, no ld_done, fetch served next cycle.
- ld_start during LOAD and dbg_req during LOAD -> both ignored/held; dbg granted first RUN cycle after FLUSH if fetch_req=0.
